// File: rtl/tree_feature_loader.sv
// Byte-stream front end for a combinational decision-tree classifier: assembles the
// feature vector, holds it SETTLE cycles, samples the class bit, returns it on a valid/ready port.
module tree_feature_loader #(
  parameter int N_FEAT = 51,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [N_FEAT-1:0] feat,
  input  logic              cls_in,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              r_class,
  output logic [15:0]       done_cnt
);

  localparam int N_BYTES = (N_FEAT + 7) / 8;
  localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int POS_W   = $clog2(N_BYTES * 8);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_FEAT-1:0] stage_q, stage_d;
  logic [N_FEAT-1:0] feat_q, feat_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              r_valid_q, r_valid_d;
  logic              r_class_q, r_class_d;
  logic [15:0]       done_cnt_q, done_cnt_d;
  logic [POS_W-1:0]  pos;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    stage_d    = stage_q;
    feat_d     = feat_q;
    cnt_d      = cnt_q;
    r_valid_d  = r_valid_q;
    r_class_d  = r_class_q;
    done_cnt_d = done_cnt_q;
    pos        = '0;
    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          // Bits of the final byte beyond N_FEAT-1 have no destination and are dropped.
          for (int b = 0; b < 8; b++) begin
            pos = POS_W'(int'(idx_q) * 8 + b);
            if (int'(pos) < N_FEAT) stage_d[pos] = s_data[b];
          end
          if (idx_q == IDX_W'(N_BYTES - 1)) begin
            feat_d  = stage_d;
            idx_d   = '0;
            cnt_d   = 4'(SETTLE);
            state_d = ST_HOLD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 4'd1) begin
          r_class_d = cls_in;
          r_valid_d = 1'b1;
          state_d   = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (r_ready) begin
          r_valid_d  = 1'b0;
          done_cnt_d = done_cnt_q + 16'd1;
          state_d    = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      stage_q    <= '0;
      feat_q     <= '0;
      cnt_q      <= '0;
      r_valid_q  <= 1'b0;
      r_class_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      stage_q    <= stage_d;
      feat_q     <= feat_d;
      cnt_q      <= cnt_d;
      r_valid_q  <= r_valid_d;
      r_class_q  <= r_class_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign s_ready  = (state_q == ST_LOAD);
  assign feat     = feat_q;
  assign r_valid  = r_valid_q;
  assign r_class  = r_class_q;
  assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_tree_feature_loader.sv
// Randomized bench for tree_feature_loader: default instance stubbed with cls_in = feat[10],
// second instance with SETTLE=4 and a per-cycle toggling class input.
module tb_tree_feature_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data, s_data4;
  logic        s_valid, s_valid4;
  logic        s_ready, s_ready4;
  logic [50:0] feat, feat4;
  logic        cls_in, cls_in4;
  logic        r_valid, r_valid4;
  logic        r_ready, r_ready4;
  logic        r_class, r_class4;
  logic [15:0] done_cnt, done_cnt4;
  logic        tog = 1'b0;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int exp_done = 0;
  int done4    = 0;
  logic [7:0]  vec [7];
  logic [50:0] exp_feat;

  tree_feature_loader #(.N_FEAT(51), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .feat(feat), .cls_in(cls_in), .r_valid(r_valid), .r_ready(r_ready),
    .r_class(r_class), .done_cnt(done_cnt)
  );

  tree_feature_loader #(.N_FEAT(51), .SETTLE(4)) dut4 (
    .clk(clk), .rst(rst), .s_data(s_data4), .s_valid(s_valid4), .s_ready(s_ready4),
    .feat(feat4), .cls_in(cls_in4), .r_valid(r_valid4), .r_ready(r_ready4),
    .r_class(r_class4), .done_cnt(done_cnt4)
  );

  assign cls_in  = feat[10];
  assign cls_in4 = tog;

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Feature vector is the little-endian concatenation of the bytes, truncated to 51 bits.
  function automatic logic [50:0] model_feat(input logic [7:0] b [7]);
    logic [63:0] acc;
    acc = '0;
    for (int k = 0; k < 7; k++) acc = acc | (64'(b[k]) << (8 * k));
    return acc[50:0];
  endfunction

  task automatic send_vec();
    for (int k = 0; k < 7; k++) begin
      int n;
      s_data  = vec[k];
      s_valid = 1'b1;
      n = 0;
      while (!s_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!s_ready) check("s_ready_timeout", 64'(s_ready), 64'd1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic do_vec(input int d);
    exp_feat = model_feat(vec);
    r_ready  = (d == 0);
    send_vec();
    @(negedge clk);
    check("hold_feat", 64'(feat), 64'(exp_feat));
    check("hold_rvalid", 64'(r_valid), 64'd0);
    check("hold_sready", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("lat_rvalid", 64'(r_valid), 64'd1);
    check("r_class", 64'(r_class), 64'(exp_feat[10]));
    if (d > 0) begin
      s_valid = 1'b1;
      s_data  = 8'hAA;
      for (int j = 0; j < d; j++) begin
        @(negedge clk);
        check("bp_rvalid", 64'(r_valid), 64'd1);
        check("bp_sready", 64'(s_ready), 64'd0);
        check("bp_feat", 64'(feat), 64'(exp_feat));
        check("bp_rclass", 64'(r_class), 64'(exp_feat[10]));
        check("bp_done", 64'(done_cnt), 64'(exp_done));
      end
      r_ready = 1'b1;
    end
    @(posedge clk); #1;
    s_valid  = 1'b0;
    exp_done = (exp_done + 1) & 16'hFFFF;
    @(negedge clk);
    check("post_rvalid", 64'(r_valid), 64'd0);
    check("post_sready", 64'(s_ready), 64'd1);
    check("done_cnt", 64'(done_cnt), 64'(exp_done));
  endtask

  task automatic run4(input int pre);
    logic [7:0] b4 [7];
    logic       e;
    e = 1'b0;
    repeat (pre) @(posedge clk);
    #1;
    check("s4_ready", 64'(s_ready4), 64'd1);
    for (int k = 0; k < 7; k++) begin
      b4[k]    = 8'($urandom);
      s_data4  = b4[k];
      s_valid4 = 1'b1;
      @(posedge clk); #1;
    end
    s_valid4 = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("s4_hold_rvalid", 64'(r_valid4), 64'd0);
      if (j == 4) e = tog;
      @(posedge clk);
    end
    @(negedge clk);
    check("s4_rvalid", 64'(r_valid4), 64'd1);
    check("s4_rclass", 64'(r_class4), 64'(e));
    check("s4_feat", 64'(feat4), 64'(model_feat(b4)));
    r_ready4 = 1'b1;
    @(posedge clk); #1;
    r_ready4 = 1'b0;
    done4++;
    @(negedge clk);
    check("s4_post_rvalid", 64'(r_valid4), 64'd0);
    check("s4_done", 64'(done_cnt4), 64'(done4));
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; r_ready = 1'b0;
    s_valid4 = 1'b0; s_data4 = '0; r_ready4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_feat", 64'(feat), 64'd0);
    check("rst_rvalid", 64'(r_valid), 64'd0);
    check("rst_rclass", 64'(r_class), 64'd0);
    check("rst_done", 64'(done_cnt), 64'd0);
    check("rst_sready", 64'(s_ready), 64'd1);
    check("rst_sready4", 64'(s_ready4), 64'd1);

    vec = '{8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_vec(0);
    check("basic_feat", 64'(feat), 64'd1 << 10);
    check("basic_rclass", 64'(r_class), 64'd1);

    for (int k = 0; k < 7; k++) vec[k] = 8'hFF;
    do_vec(0);
    check("ff_feat", 64'(feat), 64'h7FFFFFFFFFFFF);

    for (int k = 0; k < 7; k++) vec[k] = 8'($urandom);
    do_vec(20);

    for (int v = 0; v < 12; v++) begin
      for (int k = 0; k < 7; k++) vec[k] = 8'($urandom);
      do_vec(int'($urandom_range(0, 3)));
    end

    // Partial vector, then a one-cycle reset.
    for (int k = 0; k < 3; k++) begin
      s_data = 8'hFF; s_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_feat", 64'(feat), 64'd0);
    check("mrst_done", 64'(done_cnt), 64'd0);
    check("mrst_sready", 64'(s_ready), 64'd1);
    exp_done = 0;
    for (int k = 0; k < 7; k++) vec[k] = 8'h01;
    do_vec(0);
    check("mrst_vec_feat", 64'(feat), 64'h1010101010101);
    check("mrst_vec_done", 64'(done_cnt), 64'd1);

    done4 = 0;
    run4(0);
    run4(1);
    run4(2);

    force dut.done_cnt_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.done_cnt_q;
    exp_done = 16'hFFFE;
    check("preload", 64'(done_cnt), 64'hFFFE);
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 7; k++) vec[k] = 8'($urandom);
      do_vec(0);
    end
    check("wrap_zero", 64'(done_cnt), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tree_feature_loader.md
# tree_feature_loader

Sequential front end for the combinational decision-tree classifiers: accepts a byte stream of feature data, assembles a 51-bit feature vector, presents it to a classifier's `i` input, waits a fixed settle time, then samples the 1-bit class output and returns it on a valid/ready result port. It is the driving side of the classifier's `i`/`o` interface. It lets tree instances such as the class-5 trees sit behind a streaming link without any per-tree glue.

## Interface
- `N_FEAT`, default 51: feature vector width; must match the classifier's `i` width.
- `N_BYTES`, default 7: bytes per vector, equal to ceil(N_FEAT/8). Not overridable independently.
- `SETTLE`, default 1: cycles the vector is held before the class bit is sampled. Legal range 1..15.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `s_data` input, 8 bits: feature byte.
- `s_valid` input, 1 bit: `s_data` valid.
- `s_ready` output, 1 bit: loader accepts a byte.
- `feat` output, N_FEAT bits: registered feature vector. Connects to classifier `i`.
- `cls_in` input, 1 bit: classifier output `o`.
- `r_valid` output, 1 bit: result available.
- `r_ready` input, 1 bit: result consumer ready.
- `r_class` output, 1 bit: sampled class bit.
- `done_cnt` output, 16 bits: count of completed result handshakes.

## Operation
- FSM states: LOAD, HOLD, RESULT. The reset state is LOAD.
- Reset values:
  - state = LOAD
  - byte index = 0
  - staging register = 0
  - `feat` = 0
  - `r_valid` = 0
  - `r_class` = 0
  - `done_cnt` = 0
  - `s_ready` = 1
- LOAD:
  - `s_ready` = 1.
  - A byte is accepted on each edge where `s_valid` and `s_ready` are both high.
  - Byte k (k = 0..N_BYTES-1) fills staging bits [8k+7:8k], LSB first, so byte 0 bit 0 maps to `i[0]`.
  - Bits of the last byte above N_FEAT-1 are ignored. With default parameters, byte 6 bits [7:3] are dropped.
- Last byte (index N_BYTES-1) accepted:
  - On the same edge, `feat` loads the complete vector, including the final byte.
  - Byte index returns to 0, the settle counter loads SETTLE, and the FSM moves to HOLD.
- `feat` changes only on that edge. It is stable throughout HOLD and RESULT, and while the next vector is loading.
- HOLD:
  - `s_ready` = 0.
  - The counter decrements once per cycle.
  - On the edge where counter == 1: `r_class` <= `cls_in`, `r_valid` <= 1, and the FSM moves to RESULT.
- RESULT:
  - `s_ready` = 0; `r_valid` and `r_class` are held.
  - On the edge where `r_valid` and `r_ready` are both high: `r_valid` <= 0, `done_cnt` <= `done_cnt` + 1, and the FSM moves to LOAD.
- `done_cnt` wraps from 0xFFFF to 0x0000.
- `s_valid` is ignored outside LOAD. No data is captured and no error is flagged.
- `r_ready` is ignored outside RESULT.
- Reset asserted mid-vector or mid-result discards the partial vector and any pending result. `feat` returns to 0.

## Timing
- Edge E0 accepts the last byte. Result timing, measured from E0:
  - `cls_in` is sampled at edge E0+SETTLE.
  - `r_valid` rises in the cycle after that edge.
- With SETTLE=1: one HOLD cycle, and `r_valid` is high in the 2nd cycle after E0.
- If `r_ready` is already high when `r_valid` rises, the handshake completes on the next edge. `r_valid` is then high for exactly 1 cycle, and `s_ready` is high in the following cycle.
- Best-case throughput is one vector per N_BYTES + SETTLE + 1 cycles (9 with default parameters).
- No combinational path runs from `s_valid` to `s_ready`, or from `r_ready` to `r_valid`. All outputs are registered or decoded from state only.
- The classifier path from `feat` to `cls_in` must settle within SETTLE cycles. This is a constraint on the integrator.

## Test plan
- **Basic load:** stub `cls_in` = `feat[10]`; send bytes 0x00,0x04,0,0,0,0,0 with `r_ready` = 1.
  - Expect `feat` = 1<<10, `r_class` = 1, `r_valid` high for 1 cycle, `done_cnt` = 1.
- **Unused high bits and latency:** send seven 0xFF bytes.
  - Expect `feat` = 51'h7FFFFFFFFFFFF, with byte 6 bits [7:3] dropped.
  - Expect `r_valid` 2 cycles after the last-byte edge (SETTLE=1).
- **Backpressure:** hold `r_ready` = 0 for 20 cycles after `r_valid` rises, and drive `s_valid` = 1 with 0xAA throughout.
  - Expect `s_ready` = 0, `feat` unchanged, `r_class` held, and `done_cnt` unchanged until `r_ready` rises.
- **Settle counter:** SETTLE=4; toggle `cls_in` each cycle during HOLD.
  - Expect `r_class` equal to the `cls_in` value at the 4th edge after E0.
- **Mid-vector reset:** reset for 1 cycle after 3 bytes, then send a full vector of 0x01 bytes.
  - Expect `feat` = bit 0 set in every byte (0x01 pattern), with nothing left from the first 3 bytes. Expect `done_cnt` = 1.
- **Counter wrap:** preload by running 65536 vectors.
  - Expect `done_cnt` 0xFFFF → 0x0000 on the 65536th handshake, and no stall.
